req_encoder_8x3: RTL and testbench
==================================

# req_encoder_8x3

- Registered 8-to-3 request encoder with handshake: the inverse of the datapath's 3-to-8 one-hot decoder.
- Captures one-hot or multi-hot request pulses from eight sources into a pending register.
- Offers the lowest-coded pending source as a 3-bit code under a VALID/ACK handshake, and retires it on acknowledge.
- Sits between the unit's request sources (register-select / interrupt lines) and the control FSM that consumes 3-bit indices.

## Interface
- N_REQ, 8, number of request lines (fixed at 8; code width 3).
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  offer enable; when 0 no new offer starts (capture continues).
- REQ  in  [0:7]  request pulses, same bit ordering as the decoder output. Literal 8'b00000001 (REQ[7]) is code 3'b000 and literal 8'b10000000 (REQ[0]) is code 3'b111, i.e. code k ↔ REQ[7-k].
- ACK  in  1  consumer accepts current CODE.
- CODE  out  3  offered source index.
- VALID  out  1  CODE is valid and held.
- PEND  out  [0:7]  pending register, same ordering as REQ.
- DROP  out  1  sticky: a request arrived on an already-pending line.

## Operation
- Reset values: PEND=0, CODE=3'b000, VALID=0, DROP=0, state IDLE.
- Capture, every cycle: PEND_next = (PEND & ~clr) | REQ. clr is the one-hot of CODE when VALID&&ACK, else 0.
  - Set wins over clear: REQ on the line being retired leaves it pending.
- DROP sets when (REQ & PEND & ~clr) != 0 and clears only on reset.
- FSM, two states:
  - IDLE: VALID=0. If EN && PEND!=0, latch CODE = lowest code among PEND bits and go to OFFER. PEND here is the registered value; same-cycle REQ is not considered.
  - OFFER: VALID=1, CODE stable. On ACK, clear that PEND bit and go to IDLE. Otherwise stay.
- EN dropping during OFFER does not withdraw the offer; it holds until ACK.
- ACK outside OFFER is ignored.
- Priority is fixed, lowest code first. A higher code waits while lower codes keep re-requesting; no fairness.

## Timing
- REQ high in cycle 0 → PEND bit set after edge 1 → VALID/CODE asserted after edge 2 (latency 2 from idle).
- ACK sampled high at edge n → VALID low after edge n; the bit is cleared at the same edge.
- Next offer at the earliest follows at edge n+1, giving VALID high after n+1. Max throughput is one grant per 2 cycles.
- Outputs are all registered; there is no combinational path from inputs to outputs.
- RST asserted at any time, including mid-OFFER, forces reset values immediately. The outstanding offer is lost and no ACK is owed.

## Structure
- Shared package spu_pkg holds:
  - N_REQ = 8 and CODE_W = 3 constants.
  - typedef enum logic {ENC_IDLE, ENC_OFFER} enc_state_t.
- One combinational sub-module, lowest_set_8: input [0:7] vector, output 3-bit code of the lowest-code set bit, plus an any-set flag. This is the only mapping from bit order to code.
- Top level holds the PEND register, DROP flag, FSM and the CODE/VALID registers.

## Test plan
- Single request: EN=1, REQ=8'b00000100 for one cycle.
  - Expect PEND=8'b00000100, then VALID=1 with CODE=3'b010 two cycles after REQ.
  - ACK one cycle → PEND=0, VALID=0.
- Multi-hot: REQ=8'b10010001 for one cycle, ACK held high.
  - Codes 000, 100, 111 are offered in that order, with VALID low one cycle between them.
  - Ends with PEND=0 and DROP=0.
- Enable gating: EN=0, REQ=8'b01000000.
  - PEND=8'b01000000, VALID stays 0 for 10 cycles.
  - Raise EN → VALID=1, CODE=3'b110 the next cycle.
  - Drop EN before ACK → offer held until ACK.
- Clear/set collision: in OFFER with CODE=3'b000, ACK and REQ=8'b00000001 in the same cycle.
  - Bit 000 stays pending and is re-offered.
  - DROP remains 0; a second REQ=8'b00000001 while pending sets DROP=1.
- Reset mid-operation: in OFFER with PEND=8'b00010001, assert RST asynchronously between edges.
  - Outputs go to PEND=0, VALID=0, CODE=000, DROP=0 immediately.
  - After release, ACK is ignored and no offer occurs until a new REQ.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared constants and types for the request encoder slice.
package spu_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned CODE_W = 3;

    typedef enum logic {
        ENC_IDLE,
        ENC_OFFER
    } enc_state_t;

endpackage : spu_pkg

// File: rtl/lowest_set_8.sv
// Priority picker: code of the lowest-code set bit of an [0:7] request vector.
// Bit index i carries code 7-i, so a higher index means a lower code.
module lowest_set_8
    import spu_pkg::*;
(
    input  logic [0:N_REQ-1]  vec,
    output logic [CODE_W-1:0] code,
    output logic              any
);

    // Ascending scan: the last hit is the highest index, which is the lowest code
    always_comb begin
        code = '0;
        any  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                code = CODE_W'(N_REQ - 1 - i);
                any  = 1'b1;
            end
        end
    end

endmodule : lowest_set_8

// File: rtl/req_encoder_8x3.sv
// Registered 8-to-3 request encoder: captures request pulses into a pending
// register and offers the lowest pending code under a VALID/ACK handshake.
module req_encoder_8x3
    import spu_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [0:N_REQ-1]  REQ,
    input  logic              ACK,
    output logic [CODE_W-1:0] CODE,
    output logic              VALID,
    output logic [0:N_REQ-1]  PEND,
    output logic              DROP
);

    enc_state_t        state_q, state_d;
    logic [CODE_W-1:0] code_d;
    logic              valid_d;
    logic [0:N_REQ-1]  clr;
    logic [0:N_REQ-1]  pend_d;
    logic              drop_d;
    logic [CODE_W-1:0] pick_code;
    logic              pick_any;

    lowest_set_8 u_pick (
        .vec  (PEND),
        .code (pick_code),
        .any  (pick_any)
    );

    // Retire mask: code k lives at bit index N_REQ-1-k, i.e. numeric weight 2^k
    always_comb begin
        clr = '0;
        if (VALID && ACK) begin
            clr = N_REQ'(1) << CODE;
        end
    end

    // Set wins over clear; a request on a line still pending is a drop
    always_comb begin
        pend_d = (PEND & ~clr) | REQ;
        drop_d = DROP | (|(REQ & PEND & ~clr));
    end

    always_comb begin
        state_d = state_q;
        code_d  = CODE;
        valid_d = VALID;
        unique case (state_q)
            ENC_IDLE: begin
                valid_d = 1'b0;
                if (EN && pick_any) begin
                    state_d = ENC_OFFER;
                    code_d  = pick_code;
                    valid_d = 1'b1;
                end
            end
            ENC_OFFER: begin
                valid_d = 1'b1;
                if (ACK) begin
                    state_d = ENC_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ENC_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ENC_IDLE;
            CODE    <= '0;
            VALID   <= 1'b0;
            PEND    <= '0;
            DROP    <= 1'b0;
        end else begin
            state_q <= state_d;
            CODE    <= code_d;
            VALID   <= valid_d;
            PEND    <= pend_d;
            DROP    <= drop_d;
        end
    end

endmodule : req_encoder_8x3

// File: tb/tb_req_encoder_8x3.sv
// Directed self-checking bench for req_encoder_8x3.
module tb_req_encoder_8x3;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic [0:7] REQ;
    logic       ACK;
    logic [2:0] CODE;
    logic       VALID;
    logic [0:7] PEND;
    logic       DROP;

    int n_checks;
    int n_errors;

    req_encoder_8x3 dut (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .REQ   (REQ),
        .ACK   (ACK),
        .CODE  (CODE),
        .VALID (VALID),
        .PEND  (PEND),
        .DROP  (DROP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [2:0] mh_code [3];
    logic [7:0] mh_pend [3];

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST = 1'b1;
        EN  = 1'b0;
        REQ = 8'b0;
        ACK = 1'b0;
        mh_code[0] = 3'b000; mh_pend[0] = 8'b10010000;
        mh_code[1] = 3'b100; mh_pend[1] = 8'b10000000;
        mh_code[2] = 3'b111; mh_pend[2] = 8'b00000000;

        tick(); tick();
        check("rst_pend",  PEND,  8'b0);
        check("rst_valid", VALID, 8'd0);
        check("rst_code",  CODE,  8'd0);
        check("rst_drop",  DROP,  8'd0);
        RST = 1'b0;
        tick();

        // Single request
        EN  = 1'b1;
        REQ = 8'b00000100;
        tick();
        REQ = 8'b0;
        check("single_pend",   PEND,  8'b00000100);
        check("single_valid0", VALID, 8'd0);
        tick();
        check("single_valid", VALID, 8'd1);
        check("single_code",  CODE,  8'b010);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        check("single_ack_valid", VALID, 8'd0);
        check("single_ack_pend",  PEND,  8'b0);

        // Multi-hot with ACK held high
        REQ = 8'b10010001;
        ACK = 1'b1;
        tick();
        REQ = 8'b0;
        check("mh_pend", PEND, 8'b10010001);
        check("mh_valid0", VALID, 8'd0);
        for (int g = 0; g < 3; g++) begin
            tick();
            check("mh_valid", VALID, 8'd1);
            check("mh_code",  CODE,  8'(mh_code[g]));
            tick();
            check("mh_gap",      VALID, 8'd0);
            check("mh_pend_ret", PEND,  mh_pend[g]);
        end
        ACK = 1'b0;
        check("mh_drop", DROP, 8'd0);

        // Enable gating
        EN  = 1'b0;
        REQ = 8'b01000000;
        tick();
        REQ = 8'b0;
        check("en_pend", PEND, 8'b01000000);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("en_hold_off", VALID, 8'd0);
        end
        EN = 1'b1;
        tick();
        check("en_valid", VALID, 8'd1);
        check("en_code",  CODE,  8'b110);
        EN = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("en_held_valid", VALID, 8'd1);
            check("en_held_code",  CODE,  8'b110);
        end
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        check("en_ack_valid", VALID, 8'd0);
        check("en_ack_pend",  PEND,  8'b0);

        // Clear/set collision
        EN  = 1'b1;
        REQ = 8'b00000001;
        tick();
        REQ = 8'b0;
        tick();
        check("col_valid", VALID, 8'd1);
        check("col_code",  CODE,  8'b000);
        ACK = 1'b1;
        REQ = 8'b00000001;
        tick();
        ACK = 1'b0;
        REQ = 8'b0;
        check("col_gap",  VALID, 8'd0);
        check("col_pend", PEND,  8'b00000001);
        check("col_drop", DROP,  8'd0);
        tick();
        check("col_reoffer", VALID, 8'd1);
        check("col_recode",  CODE,  8'b000);
        REQ = 8'b00000001;
        tick();
        REQ = 8'b0;
        check("drop_set", DROP, 8'd1);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        check("drop_sticky", DROP, 8'd1);
        check("drop_pend",   PEND, 8'b0);

        // Asynchronous reset mid-offer
        REQ = 8'b00010001;
        tick();
        REQ = 8'b0;
        tick();
        check("mr_valid", VALID, 8'd1);
        check("mr_code",  CODE,  8'b000);
        check("mr_pend",  PEND,  8'b00010001);
        #2;
        RST = 1'b1;
        #1;
        check("ar_pend",  PEND,  8'b0);
        check("ar_valid", VALID, 8'd0);
        check("ar_code",  CODE,  8'd0);
        check("ar_drop",  DROP,  8'd0);
        @(negedge CLK);
        RST = 1'b0;
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        check("post_ack_valid", VALID, 8'd0);
        check("post_ack_pend",  PEND,  8'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_idle", VALID, 8'd0);
        end
        REQ = 8'b00000010;
        tick();
        REQ = 8'b0;
        tick();
        check("post_valid", VALID, 8'd1);
        check("post_code",  CODE,  8'b001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_req_encoder_8x3
